// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file answering the write-back stage; traps, mret, 64-bit counters.
// Latency: read is combinational, writes/traps land at the clock edge; no backpressure (always ready).
module csr_file #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        is_csr_i,
  input  logic        we_exc_i,
  input  logic [31:0] mcause_d_i,
  input  logic [31:0] mepc_d_i,
  input  logic [31:0] mtval_d_i,
  input  logic        mret_i,
  input  logic        retire_i,
  output logic [31:0] data_out_o,
  output logic        illegal_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q, mpie_q;
  logic [31:0] mie_reg_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] rd_val, wr_val;
  logic        impl, op_ok, wr_intent, csr_wr;

  always_comb begin
    rd_val = 32'h0;
    impl   = 1'b1;
    case (addr_i)
      12'h300: rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      12'h301: rd_val = MISA_VAL;
      12'h304: rd_val = mie_reg_q;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = 32'h0;
      12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
      12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
      12'hB02, 12'hC02: rd_val = minstret_q[31:0];
      12'hB82, 12'hC82: rd_val = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: rd_val = 32'h0;
      12'hF14: rd_val = HART_ID;
      default: impl = 1'b0;
    endcase
  end

  always_comb begin
    wr_val = data_i;
    op_ok  = 1'b1;
    case (funct3_i)
      3'b001, 3'b101: wr_val = data_i;
      3'b010, 3'b110: wr_val = rd_val | data_i;
      3'b011, 3'b111: wr_val = rd_val & ~data_i;
      default:        op_ok  = 1'b0;
    endcase
  end

  // Only the swap forms write unconditionally; set/clear with a zero mask is a pure read.
  assign wr_intent  = (funct3_i[1:0] == 2'b01) || (data_i != 32'h0);
  assign illegal_o  = is_csr_i && (!op_ok || !impl || (wr_intent && addr_i[11:10] == 2'b11));
  assign csr_wr     = is_csr_i && !illegal_o && wr_intent && !we_exc_i && !mret_i;
  assign data_out_o = (is_csr_i && !illegal_o) ? rd_val : 32'h0;
  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_reg_q  <= 32'h0;
      mtvec_q    <= RESET_MTVEC & ~32'h3;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (we_exc_i) begin
        mepc_q   <= mepc_d_i & ~32'h3;
        mcause_q <= mcause_d_i;
        mtval_q  <= mtval_d_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_wr) begin
        case (addr_i)
          12'h300: begin
            mie_q  <= wr_val[3];
            mpie_q <= wr_val[7];
          end
          12'h304: mie_reg_q  <= wr_val & 32'h0000_0888;
          12'h305: mtvec_q    <= wr_val & ~32'h3;
          12'h340: mscratch_q <= wr_val;
          12'h341: mepc_q     <= wr_val & ~32'h3;
          12'h342: mcause_q   <= wr_val;
          12'h343: mtval_q    <= wr_val;
          default: ;
        endcase
      end

      // A software write to either counter half suppresses that cycle's increment.
      if (csr_wr && addr_i == 12'hB00)      mcycle_q[31:0]  <= wr_val;
      else if (csr_wr && addr_i == 12'hB80) mcycle_q[63:32] <= wr_val;
      else                                  mcycle_q        <= mcycle_q + 64'd1;

      if (csr_wr && addr_i == 12'hB02)      minstret_q[31:0]  <= wr_val;
      else if (csr_wr && addr_i == 12'hB82) minstret_q[63:32] <= wr_val;
      else if (retire_i && !we_exc_i)       minstret_q        <= minstret_q + 64'd1;
    end
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32I pipeline; the responder side of the write-back stage's CSR/exception interface.
- Services CSRRW/RS/RC (+ immediate forms) issued from write-back, with a combinational read and a write at the clock edge.
- Latches trap state (mepc/mcause/mtval/mstatus) on an exception and restores it on mret.
- Maintains 64-bit mcycle/minstret counters; supplies mtvec/mepc to fetch.

Parameters:
RESET_MTVEC, 32'h0000_0000, mtvec value after reset
MISA_VAL, 32'h4000_0100, read-only misa contents (RV32I)
HART_ID, 32'h0000_0000, read-only mhartid contents

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
funct3_i  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
addr_i  in  12  CSR address
data_i  in  32  rs1 value, or zimm already zero-extended for the I forms
is_csr_i  in  1  a valid CSR instruction is in write-back this cycle
we_exc_i  in  1  exception taken this cycle
mcause_d_i  in  32  cause to latch on trap
mepc_d_i  in  32  faulting PC
mtval_d_i  in  32  trap value
mret_i  in  1  mret retiring this cycle
retire_i  in  1  an instruction retires this cycle
data_out_o  out  32  old CSR value (combinational)
illegal_o  out  1  CSR access is illegal (combinational)
mtvec_o  out  32  trap vector
mepc_o  out  32  return PC for mret

Behaviour:
- Read path
  - data_out_o = current value of addr_i; no latency.
  - Read data is the pre-write value (read-modify-write semantics).
  - data_out_o = 0 when illegal_o = 1 or is_csr_i = 0.
- Write value by op
  - RW/RWI: new = data_i.
  - RS/RSI: new = old | data_i.
  - RC/RCI: new = old & ~data_i.
  - RS/RC/RSI/RCI with data_i == 0: no write, and read-only addresses are legal.
- Implemented CSRs and write masks
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
  - misa 0x301: reads MISA_VAL; writes are ignored (WARL).
  - mie 0x304: bits 3, 7, 11 writable; others read 0.
  - mtvec 0x305: bits [1:0] forced 00 (direct mode only).
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] forced 00.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: reads 0; writes are ignored.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: writable.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows of the machine counters.
  - mvendorid 0xF11, marchid 0xF12, mimpid 0xF13 read 0; mhartid 0xF14 reads HART_ID.
- illegal_o = is_csr_i & (any of):
  - funct3 is 000 or 100;
  - addr_i is not implemented;
  - write intent to addr_i[11:10] == 2'b11.
- When illegal_o = 1, no CSR state changes.
- Priority per clock edge: rst_i > we_exc_i > mret_i > CSR write.
- Trap (we_exc_i = 1)
  - mepc <= mepc_d_i & ~3; mcause <= mcause_d_i; mtval <= mtval_d_i.
  - MPIE <= MIE; MIE <= 0.
  - Any concurrent CSR write or mret is dropped.
- mret (mret_i = 1, no trap): MIE <= MPIE; MPIE <= 1.
- Counters
  - mcycle (64-bit) increments every cycle.
  - minstret (64-bit) increments when retire_i & ~we_exc_i.
  - Low word wraps 0xFFFF_FFFF -> 0 with carry into the high word; full 64-bit wrap -> 0.
  - A CSR write to either half in the same cycle wins: the written half takes the written value, the other half holds, and there is no increment that cycle.
- Reset values
  - All registers 0, except mtvec = RESET_MTVEC and MPP = 11.
  - Outputs after reset: mtvec_o = RESET_MTVEC, mepc_o = 0; data_out_o/illegal_o follow the inputs combinationally.
  - Reset asserted mid-stream overrides traps, writes and counting in that same cycle.
- mtvec_o and mepc_o reflect registered values; they update the cycle after a write or trap.

Test Plan:
- Reset: rst_i 1 cycle -> mtvec_o = RESET_MTVEC, mcycle reads 0 the cycle after release, mstatus reads 0x0000_1800.
- CSR ops on mscratch:
  - RW 0x340 data_i = 0xA5A5_0003 -> data_out_o = 0 the same cycle.
  - RS data_i = 0x0000_00F0 -> data_out_o = 0xA5A5_0003, new value 0xA5A5_00F3.
  - RC data_i = 0xA5A5_0000 -> new value 0x0000_00F3.
- Trap vs write: MIE = 1, we_exc_i plus CSRRW mscratch, mepc_d_i = 0x0000_1007, mcause_d_i = 2 -> mepc_o = 0x1004, mcause = 2, MPIE = 1, MIE = 0, mscratch unchanged; mret next cycle -> MIE = 1, MPIE = 1.
- Counter carry: write mcycle = 0xFFFF_FFFE -> two cycles later mcycleh += 1 and mcycle = 0; retire_i with we_exc_i -> minstret does not increment.
- Illegal accesses:
  - CSRRW 0xC00 -> illegal_o = 1, no state change.
  - CSRRS 0xC00 with data_i = 0 -> legal, returns cycle.
  - Address 0x7C0 -> illegal_o = 1, data_out_o = 0.
- WARL masks: write 0xFFFF_FFFF to mtvec, mie, mstatus -> read back 0xFFFF_FFFC, 0x0000_0888, 0x0000_1888.
